// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, FSM states, Nk/Nr lookup,
// expansion latencies and GF(2^8) helpers (xtime, multiply, S-box).
package aes_pkg;

  typedef enum logic [1:0] {
    KLEN_128  = 2'b00,
    KLEN_192  = 2'b01,
    KLEN_256  = 2'b10,
    KLEN_RSVD = 2'b11
  } klen_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_ROUND,
    ST_DONE
  } state_e;

  localparam int unsigned E_128    = 40;
  localparam int unsigned E_192    = 46;
  localparam int unsigned E_256    = 52;
  localparam int unsigned KS_WORDS = 60;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(input klen_e klen);
    case (klen)
      KLEN_128: return 4'd4;
      KLEN_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input klen_e klen);
    case (klen)
      KLEN_128: return 4'd10;
      KLEN_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  function automatic int unsigned e_of(input klen_e klen);
    case (klen)
      KLEN_128: return E_128;
      KLEN_192: return E_192;
      default:  return E_256;
    endcase
  endfunction

  // Only the key bits selected by key_len take part in expansion and tagging.
  function automatic logic [255:0] key_mask(input logic [255:0] k, input klen_e klen);
    case (klen)
      KLEN_128: return {k[255:128], 128'h0};
      KLEN_192: return {k[255:64], 64'h0};
      default:  return k;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

endpackage

// File: rtl/add_round_key.sv
// AES AddRoundKey.
module add_round_key (
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  output logic [127:0] o_state
);

  assign o_state = i_state ^ i_key;

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion: one word per step into a 60-word store,
// with a tag of the last fully expanded key for reuse.
module aes_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  klen_e        i_klen,
  input  logic [255:0] i_key,
  input  logic [3:0]   i_round,
  output logic         o_hit,
  output logic         o_last,
  output logic [127:0] o_rk
);

  logic [31:0]  r_w [KS_WORDS];
  logic [5:0]   r_wi;
  logic [5:0]   r_lastw;
  logic [2:0]   r_kmod;
  logic [3:0]   r_nk;
  logic [7:0]   r_rcon;
  logic [255:0] r_tag_key;
  klen_e        r_tag_len;
  logic         r_tag_vld;

  logic [31:0]  w_prev, w_back, w_sub_in, w_sub, w_t, w_new;
  logic [5:0]   w_rk_base;

  assign w_prev   = r_w[r_wi - 6'd1];
  assign w_back   = r_w[r_wi - {2'b00, r_nk}];
  assign w_sub_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sub
    subByte u_sb (
      .i_byte (w_sub_in[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  always_comb begin
    w_t = w_prev;
    if (r_kmod == 3'd0) begin
      w_t = w_sub ^ {r_rcon, 24'h0};
    end else if (r_nk == 4'd8 && r_kmod == 3'd4) begin
      w_t = w_sub;
    end
  end

  assign w_new  = w_back ^ w_t;
  assign o_last = (r_wi == r_lastw);
  assign o_hit  = r_tag_vld && (r_tag_len == i_klen) &&
                  (r_tag_key == key_mask(i_key, i_klen));

  assign w_rk_base = {i_round, 2'b00};
  assign o_rk = {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                 r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wi      <= '0;
      r_lastw   <= '0;
      r_kmod    <= '0;
      r_nk      <= '0;
      r_rcon    <= '0;
      r_tag_key <= '0;
      r_tag_len <= KLEN_128;
      r_tag_vld <= 1'b0;
    end else if (i_load) begin
      // The tag is recorded now but only trusted once the last word lands.
      r_wi      <= {2'b00, nk_of(i_klen)};
      r_lastw   <= {nr_of(i_klen) + 4'd1, 2'b00} - 6'd1;
      r_kmod    <= '0;
      r_nk      <= nk_of(i_klen);
      r_rcon    <= RCON_INIT;
      r_tag_key <= key_mask(i_key, i_klen);
      r_tag_len <= i_klen;
      r_tag_vld <= 1'b0;
    end else if (i_step) begin
      r_wi   <= r_wi + 6'd1;
      r_kmod <= ({1'b0, r_kmod} == r_nk - 4'd1) ? 3'd0 : r_kmod + 3'd1;
      if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
      if (o_last) r_tag_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int unsigned k = 0; k < 8; k++) begin
        r_w[k] <= i_key[255 - 32*k -: 32];
      end
    end else if (i_step) begin
      r_w[r_wi] <= w_new;
    end
  end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns applied independently to the four state columns.
module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    o_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      o_state[127 - 32*c -: 32] = mix_col(i_state[127 - 32*c -: 32]);
    end
  end

endmodule

// File: rtl/shift_rows.sv
// AES ShiftRows on a column-major state, byte 0 at [127:120].
module shift_rows (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  always_comb begin
    o_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o_state[127 - 8*(r + 4*c) -: 8] = i_state[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
  end

endmodule

// File: rtl/subByte.sv
// Single-byte AES S-box substitution.
module subByte
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox(i_byte);

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryptor: one round per cycle, on-the-fly key
// expansion with optional reuse of the last expanded key.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE   = 1'b1,
  parameter bit ERR_ON_RSVD = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         err,
  output logic         busy
);

  state_e       r_state, w_next;
  logic [127:0] r_blk;
  logic [3:0]   r_round;
  logic [3:0]   r_nr;
  logic         r_err;

  klen_e        w_klen;
  logic         w_rsvd_err, w_hit, w_load, w_step, w_ks_last, w_last_round;
  logic [127:0] w_rk, w_sb, w_sr, w_mc, w_pre, w_ark;

  always_comb begin
    w_klen = klen_e'(key_len);
    if (key_len == KLEN_RSVD && !ERR_ON_RSVD) w_klen = KLEN_256;
  end

  assign w_rsvd_err   = ERR_ON_RSVD && (key_len == KLEN_RSVD);
  assign w_load       = (r_state == ST_IDLE) && in_valid && !w_rsvd_err && !(KEY_CACHE && w_hit);
  assign w_step       = (r_state == ST_EXPAND);
  assign w_last_round = (r_round == r_nr);

  aes_key_sched u_ks (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_klen  (w_klen),
    .i_key   (key),
    .i_round (r_round),
    .o_hit   (w_hit),
    .o_last  (w_ks_last),
    .o_rk    (w_rk)
  );

  for (genvar g = 0; g < 16; g++) begin : g_sb
    subByte u_sb (
      .i_byte (r_blk[8*g +: 8]),
      .o_byte (w_sb[8*g +: 8])
    );
  end

  shift_rows    u_sr  (.i_state(w_sb), .o_state(w_sr));
  mix_columns   u_mc  (.i_state(w_sr), .o_state(w_mc));
  assign w_pre = w_last_round ? w_sr : w_mc;
  add_round_key u_ark (.i_state(w_pre), .i_key(w_rk), .o_state(w_ark));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_rsvd_err)              w_next = ST_DONE;
          else if (KEY_CACHE && w_hit) w_next = ST_ROUND;
          else                         w_next = ST_EXPAND;
        end
      end
      ST_EXPAND: if (w_ks_last)    w_next = ST_ROUND;
      ST_ROUND:  if (w_last_round) w_next = ST_DONE;
      ST_DONE:   if (out_ready)    w_next = ST_IDLE;
      default:                     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk   <= '0;
      r_round <= '0;
      r_nr    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_blk   <= w_rsvd_err ? '0 : (in ^ key[255:128]);
            r_round <= 4'd1;
            r_nr    <= nr_of(w_klen);
            r_err   <= w_rsvd_err;
          end
        end
        ST_ROUND: begin
          r_blk <= w_ark;
          if (!w_last_round) r_round <= r_round + 4'd1;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_err   <= 1'b0;
            r_round <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign err       = (r_state == ST_DONE) && r_err;
  assign out       = (r_state == ST_DONE) ? r_blk : '0;

endmodule

// File: doc/aes_enc_iter.md
AES_ENC_ITER -- requirements
Module: aes_enc_iter

Interface
REQ-001 SHALL have parameter KEY_CACHE, default 1: when 1, round keys are reused if key and key_len match the last expanded pair.
REQ-002 SHALL have parameter ERR_ON_RSVD, default 1: when 1, key_len=11 is rejected with err; when 0, it is treated as 256.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 key_len  input  2  00=128, 01=192, 10=256, 11=reserved.
REQ-008 key  input  256  cipher key, MSB-aligned; 128-bit key in key[255:128], 192-bit key in key[255:64], unused LSBs ignored.
REQ-009 in  input  128  plaintext block, byte 0 at [127:120].
REQ-010 out_valid  output  1  ciphertext valid.
REQ-011 out_ready  input  1  consumer accepts.
REQ-012 out  output  128  ciphertext.
REQ-013 err  output  1  qualifies out_valid; 1 = reserved key_len rejected, out=0.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states IDLE, EXPAND, ROUND, DONE; in_ready=1 only in IDLE.
REQ-016 Accept on in_valid&&in_ready: capture key, key_len, Nk/Nr; state <= in ^ key[255:128] (round key 0); round counter <= 1.
REQ-017 Nk/Nr: 4/10, 6/12, 8/14 for 128/192/256.
REQ-018 EXPAND: generate one 32-bit word w[i] per cycle, i from Nk to 4*(Nr+1)-1, into a 60x32 round-key store; w[0..Nk-1] loaded from key at accept.
REQ-019 w[i] = w[i-Nk] ^ t; t = SubWord(RotWord(w[i-1]))^Rcon when i mod Nk = 0; t = SubWord(w[i-1]) when Nk=8 and i mod 8 = 4; else t = w[i-1].
REQ-020 Rcon sequence 01,02,04,08,10,20,40,80,1B,36 in byte [31:24], advanced by GF(2^8) xtime on each i mod Nk = 0.
REQ-021 EXPAND length E = 40/46/52 cycles for 128/192/256; then go to ROUND.
REQ-022 Cache hit (KEY_CACHE=1, key bits used by key_len and key_len both equal the stored pair, cache valid): skip EXPAND, go to ROUND directly.
REQ-023 ROUND: one round per cycle: SubBytes, ShiftRows, MixColumns (omitted when round=Nr), AddRoundKey with words w[4r..4r+3]; after round Nr go to DONE.
REQ-024 Latency accept edge to out_valid rising: E+Nr cycles on miss (50/58/66), Nr cycles on hit (10/12/14).
REQ-025 DONE: out_valid=1, out and err stable until out_valid&&out_ready, then IDLE; in_ready stays 0 while DONE is held.
REQ-026 Reserved key_len with ERR_ON_RSVD=1: accepted, go straight to DONE next cycle with err=1, out=0; cache unchanged.
REQ-027 in_valid while busy is ignored and not queued; inputs other than out_ready are don't-care outside IDLE.
REQ-028 Cache becomes valid only when EXPAND completes its last word; a reset during EXPAND leaves it invalid.

Reset
REQ-029 rst SHALL take effect at the next edge from any state, including mid-EXPAND and mid-ROUND: state IDLE, in_ready=1, out_valid=0, err=0, busy=0, out=0, cache invalid, counters 0; any in-flight block is discarded.

Structure
REQ-030 Shared package aes_pkg holds key_len encodings, Nk/Nr lookup, the Rcon table/xtime function, and E latency constants.
REQ-031 Round datapath reuses existing subByte, shift_rows, mix_columns, add_round_key modules.
REQ-032 One sub-module aes_key_sched holds the word generator, Rcon state, round-key store, and cache tag.

Verification
REQ-033 AES-128: key 000102..0f, in 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 50 cycles after accept.
REQ-034 AES-192: key 000102..17, same in -> out dda97ca4864cdfe06eaf70a0ec0d7191 after 58 cycles; AES-256: key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 66 cycles.
REQ-035 Back-to-back AES-128 with same key, second in = 0 -> second out_valid after 10 cycles; change key LSB -> 50 cycles again; changing key[127:0] under key_len=00 still hits.
REQ-036 key_len=11, ERR_ON_RSVD=1 -> out_valid next cycle with err=1, out=0; a following valid AES-128 request still hits a previously valid cache.
REQ-037 out_ready held low 20 cycles in DONE -> out stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-038 rst asserted at cycle 20 of EXPAND -> next cycle all outputs at reset values; repeat of same request takes 50 cycles (cache miss) with correct ciphertext.
